alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

- Sequences single ALU operations on behalf of an upstream requester.
- Collects operand A and operand B, which may arrive in separate beats, and enforces a 16-cycle pairing window.
- Issues the command to the ALU with the correct `INP_VALID` encoding for the command's operand class, waits out the ALU latency, and returns a registered result.
- Sits between the stimulus/host side and the ALU; guarantees by construction the operand-validity rules that the ALU checkers enforce.

## Interface

Parameters:
- `WIDTH`, 8: operand width; results are `WIDTH+1` bits.
- `CMD_WIDTH`, 4: command width.
- `TIMEOUT`, 16: maximum number of COLLECT cycles allowed to complete an operand pair.
- `LAT`, 1: ALU result latency in cycles, for all commands except multiply.
- `MUL_LAT`, 2: ALU latency for MODE=1, CMD 9 and 10.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` in 1: clock; everything is updated on the rising edge.
  - `rst` in 1: synchronous, active-high reset.
- Upstream request:
  - `in_valid` in 1: request/operand beat.
  - `in_ready` out 1: beat accepted when `in_valid && in_ready`.
  - `in_mode` in 1: 1 = arithmetic, 0 = logical. Sampled only in IDLE.
  - `in_cmd` in CMD_WIDTH: command. Sampled only in IDLE.
  - `in_cin` in 1: carry-in. Sampled only in IDLE.
  - `in_inp_valid` in 2: bit0 = `in_opa` present, bit1 = `in_opb` present.
  - `in_opa`, `in_opb` in WIDTH: operands.
- ALU side:
  - `alu_ce` out 1: one-cycle issue strobe.
  - `alu_mode`, `alu_cmd`, `alu_cin` out 1 / CMD_WIDTH / 1: latched command fields.
  - `alu_inp_valid` out 2: required-operand mask.
  - `alu_opa`, `alu_opb` out WIDTH: operands.
  - `alu_res` in WIDTH+1; `alu_err`, `alu_oflow`, `alu_cout`, `alu_g`, `alu_l`, `alu_e` in 1: ALU results.
- Result:
  - `out_valid` out 1: one-cycle result pulse; there is no backpressure.
  - `out_res` out WIDTH+1.
  - `out_err`, `out_oflow`, `out_cout`, `out_g`, `out_l`, `out_e` out 1.
  - `out_timeout` out 1: set when the pairing window expired.

## Operation

Required-operand mask `req`, decoded from the latched mode/cmd:
- MODE=1:
  - CMD 0-3 and 8-10 → 11.
  - CMD 4, 5 → 01.
  - CMD 6, 7 → 10.
  - CMD ≥ 11 → illegal.
- MODE=0:
  - CMD 0-5, 12, 13 → 11.
  - CMD 6, 8, 9 → 01.
  - CMD 7, 10, 11 → 10.
  - CMD ≥ 14 → illegal.

State machine: IDLE, COLLECT, ISSUE, WAIT, DONE. `in_ready` = 1 in IDLE and COLLECT, 0 otherwise.

- **IDLE**
  - On an accepted beat, latch mode/cmd/cin, latch each operand whose `in_inp_valid` bit is set, and set the held mask `have` = `in_inp_valid`.
  - Illegal command → DONE with `out_err`=1; nothing is issued.
  - `(have & req) == req` → ISSUE.
  - Otherwise → COLLECT with `timer`=0.
- **COLLECT**
  - An accepted beat latches only the flagged operands; command fields on the bus are ignored.
  - A later operand value overwrites an earlier one.
  - Pair complete (including on the beat just accepted) → ISSUE.
  - Otherwise `timer` increments; when `timer` reaches TIMEOUT-1 without completion → DONE with `out_err`=1, `out_timeout`=1, and the ALU is not issued.
- **ISSUE**
  - Lasts one cycle with `alu_ce`=1 and `alu_inp_valid`=`req`.
  - Operands outside `req` are driven 0.
  - Loads the latency counter with LAT, or MUL_LAT for MODE=1 CMD 9/10 → WAIT.
- **WAIT**
  - `alu_ce`=0 and the `alu_*` drive is held stable.
  - The counter decrements each cycle; at the final cycle, capture the `alu_*` results into `out_*` → DONE.
- **DONE**
  - `out_valid`=1 for one cycle → IDLE.
  - `out_*` holds its value until the next DONE.
  - `out_timeout` is cleared at the next issue.

Reset:
- `rst` in any state forces IDLE at the next edge.
- `have`, `timer` and all `alu_*`/`out_*` registers are cleared to 0.
- No `out_valid` is produced for an aborted operation.
- Behaviour is identical with `rst` asserted mid-COLLECT or mid-WAIT.

## Timing

- Reset values:
  - `in_ready`=1 after reset (IDLE).
  - All other outputs are 0.
- Accept at cycle T with both operands present, LAT=1:
  - ISSUE (`alu_ce`=1) at T+1.
  - Result captured at the end of T+1+LAT.
  - `out_valid` at T+2+LAT, which is T+3 for LAT=1.
- Split operands:
  - First beat at T, second at T+k (1 ≤ k ≤ TIMEOUT) → ISSUE at T+k+1.
  - A beat at T+TIMEOUT is still accepted.
  - With no completion, DONE is at T+TIMEOUT+1 with `out_timeout`=1.
- Illegal command at T → `out_valid` with `out_err`=1 at T+1; `alu_ce` is never asserted.
- Throughput: one operation per LAT+3 cycles; there is no overlap between operations.
- A beat presented while `in_ready`=0 is not consumed; the requester must hold it.

## Test plan

- MODE=1 CMD=0 (ADD), OPA=8'h0F, OPB=8'h01, INP_VALID=11 at T → `alu_ce` at T+1 with `alu_inp_valid`=11; `out_valid` at T+3 with `out_res`=9'h010.
- MODE=0 CMD=0 (AND): OPA=8'hF0 with valid=01 at T, OPB=8'h3C with valid=10 at T+5 → ISSUE at T+6, `out_res`=9'h030.
- MODE=1 CMD=0 with only OPA supplied at T, no further beats → `out_valid` at T+17 with `out_err`=1 and `out_timeout`=1; `alu_ce` stays 0 throughout.
- MODE=1 CMD=4 (INC_A) with valid=11 and OPB=8'hAA → `alu_inp_valid`=01 and `alu_opb`=0 at issue. MODE=1 CMD=9 with LAT=1, MUL_LAT=2 → `out_valid` at T+4.
- Illegal MODE=1 CMD=12 → `out_err`=1 at T+1 and no ALU issue. `rst` pulsed during WAIT → IDLE next cycle, outputs 0, no `out_valid`.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
// Bundles the three buses around the ALU operation sequencer:
//   - upstream request: in_valid/in_ready handshake with mode, cmd, cin,
//     operand-present mask and operands
//   - ALU side: issue strobe, latched command fields, required-operand mask,
//     operands out; result and flags back
//   - result: one-cycle out_valid pulse with registered result, flags and
//     a pairing-window timeout indication
// The slave modport is the sequencer. The master modport is everything
// around it: the requester, the ALU and the result consumer.
interface alu_op_sequencer_if #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_mode;
    logic [CMD_WIDTH-1:0] in_cmd;
    logic                 in_cin;
    logic [1:0]           in_inp_valid;
    logic [WIDTH-1:0]     in_opa;
    logic [WIDTH-1:0]     in_opb;

    logic                 alu_ce;
    logic                 alu_mode;
    logic [CMD_WIDTH-1:0] alu_cmd;
    logic                 alu_cin;
    logic [1:0]           alu_inp_valid;
    logic [WIDTH-1:0]     alu_opa;
    logic [WIDTH-1:0]     alu_opb;
    logic [WIDTH:0]       alu_res;
    logic                 alu_err;
    logic                 alu_oflow;
    logic                 alu_cout;
    logic                 alu_g;
    logic                 alu_l;
    logic                 alu_e;

    logic                 out_valid;
    logic [WIDTH:0]       out_res;
    logic                 out_err;
    logic                 out_oflow;
    logic                 out_cout;
    logic                 out_g;
    logic                 out_l;
    logic                 out_e;
    logic                 out_timeout;

    modport master (
        output in_valid, in_mode, in_cmd, in_cin, in_inp_valid, in_opa, in_opb,
        input  in_ready,
        input  alu_ce, alu_mode, alu_cmd, alu_cin, alu_inp_valid, alu_opa, alu_opb,
        output alu_res, alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e,
        input  out_valid, out_res, out_err, out_oflow, out_cout, out_g, out_l, out_e,
        input  out_timeout
    );

    modport slave (
        input  in_valid, in_mode, in_cmd, in_cin, in_inp_valid, in_opa, in_opb,
        output in_ready,
        output alu_ce, alu_mode, alu_cmd, alu_cin, alu_inp_valid, alu_opa, alu_opb,
        input  alu_res, alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e,
        output out_valid, out_res, out_err, out_oflow, out_cout, out_g, out_l, out_e,
        output out_timeout
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Sequences one ALU operation at a time for an upstream requester. Operands
// A and B may arrive in separate beats; the pair must complete within a
// TIMEOUT-cycle window. Once complete, the command is issued to the ALU for
// one cycle with the operand mask its class requires (operands outside the
// mask driven to 0), the ALU latency is waited out and the result is
// returned as a registered one-cycle pulse.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - alu_op_sequencer_if.slave: request, ALU and result buses
module alu_op_sequencer #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4,
    parameter int TIMEOUT   = 16,
    parameter int LAT       = 1,
    parameter int MUL_LAT   = 2
) (
    input logic               clk,
    input logic               rst,
    alu_op_sequencer_if.slave bus
);
    localparam int MAX_LAT = (MUL_LAT > LAT) ? MUL_LAT : LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam int TMR_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic                 mode_q, cin_q;
    logic [CMD_WIDTH-1:0] cmd_q;
    logic [WIDTH-1:0]     opa_q, opb_q;
    logic [1:0]           have_q;
    logic [TMR_W-1:0]     timer_q;
    logic [CNT_W-1:0]     lat_cnt;

    logic                 alu_mode_q, alu_cin_q;
    logic [CMD_WIDTH-1:0] alu_cmd_q;
    logic [1:0]           alu_inp_valid_q;
    logic [WIDTH-1:0]     alu_opa_q, alu_opb_q;

    logic [WIDTH:0]       out_res_q;
    logic                 out_err_q, out_oflow_q, out_cout_q;
    logic                 out_g_q, out_l_q, out_e_q, out_timeout_q;

    logic                 in_ready_c, alu_ce_c, out_valid_c;
    logic                 accept;
    logic                 cur_mode, cur_cin;
    logic [CMD_WIDTH-1:0] cur_cmd;
    logic [WIDTH-1:0]     cur_opa, cur_opb;
    logic [1:0]           beat_have, cur_have, cur_req;
    logic                 cur_illegal, pair_done, timer_done, lat_done, is_mul;

    // Returns {illegal, required-operand mask} for a mode/command pair.
    function automatic logic [2:0] decode_req(input logic mode,
                                              input logic [CMD_WIDTH-1:0] cmd);
        int unsigned c;
        c = 32'(cmd);
        decode_req = 3'b100;
        if (mode) begin
            if (c <= 3 || (c >= 8 && c <= 10)) decode_req = 3'b011;
            else if (c == 4 || c == 5)         decode_req = 3'b001;
            else if (c == 6 || c == 7)         decode_req = 3'b010;
        end else begin
            if (c <= 5 || c == 12 || c == 13)       decode_req = 3'b011;
            else if (c == 6 || c == 8 || c == 9)    decode_req = 3'b001;
            else if (c == 7 || c == 10 || c == 11)  decode_req = 3'b010;
        end
    endfunction

    // The "current" view merges the beat being accepted this cycle with what
    // is already held, so completion can be recognised on the completing beat
    // itself. In IDLE the command fields come straight from the bus.
    always_comb begin
        accept    = bus.in_valid && in_ready_c;
        beat_have = accept ? bus.in_inp_valid : 2'b00;
        if (state == S_IDLE) begin
            cur_mode = bus.in_mode;
            cur_cmd  = bus.in_cmd;
            cur_cin  = bus.in_cin;
            cur_have = beat_have;
        end else begin
            cur_mode = mode_q;
            cur_cmd  = cmd_q;
            cur_cin  = cin_q;
            cur_have = have_q | beat_have;
        end
        cur_opa = beat_have[0] ? bus.in_opa : opa_q;
        cur_opb = beat_have[1] ? bus.in_opb : opb_q;
        {cur_illegal, cur_req} = decode_req(cur_mode, cur_cmd);
        pair_done  = ((cur_have & cur_req) == cur_req);
        timer_done = (timer_q == TMR_W'(TIMEOUT - 1));
        lat_done   = (lat_cnt == CNT_W'(1));
        is_mul     = alu_mode_q && (alu_cmd_q == CMD_WIDTH'(9) || alu_cmd_q == CMD_WIDTH'(10));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cur_illegal)    next_state = S_DONE;
                    else if (pair_done) next_state = S_ISSUE;
                    else                next_state = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (pair_done)       next_state = S_ISSUE;
                else if (timer_done) next_state = S_DONE;
            end
            S_ISSUE: next_state = S_WAIT;
            S_WAIT:  if (lat_done) next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_c  = (state == S_IDLE) || (state == S_COLLECT);
        alu_ce_c    = (state == S_ISSUE);
        out_valid_c = (state == S_DONE);
    end

    // Operand collection, ALU drive and result registers. The ALU drive is
    // loaded on the way into ISSUE and then left alone so it stays stable
    // through WAIT. Error completions (illegal command, expired window)
    // clear the result and flags; out_timeout is only ever cleared by an
    // issue, so an illegal command leaves it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q          <= 1'b0;
            cmd_q           <= '0;
            cin_q           <= 1'b0;
            opa_q           <= '0;
            opb_q           <= '0;
            have_q          <= '0;
            timer_q         <= '0;
            lat_cnt         <= '0;
            alu_mode_q      <= 1'b0;
            alu_cmd_q       <= '0;
            alu_cin_q       <= 1'b0;
            alu_inp_valid_q <= '0;
            alu_opa_q       <= '0;
            alu_opb_q       <= '0;
            out_res_q       <= '0;
            out_err_q       <= 1'b0;
            out_oflow_q     <= 1'b0;
            out_cout_q      <= 1'b0;
            out_g_q         <= 1'b0;
            out_l_q         <= 1'b0;
            out_e_q         <= 1'b0;
            out_timeout_q   <= 1'b0;
        end else begin
            if (state == S_IDLE && accept) begin
                mode_q <= bus.in_mode;
                cmd_q  <= bus.in_cmd;
                cin_q  <= bus.in_cin;
            end
            if (accept) begin
                opa_q  <= cur_opa;
                opb_q  <= cur_opb;
                have_q <= cur_have;
            end

            if (state == S_COLLECT) timer_q <= timer_q + TMR_W'(1);
            else                    timer_q <= '0;

            if (next_state == S_ISSUE) begin
                alu_mode_q      <= cur_mode;
                alu_cmd_q       <= cur_cmd;
                alu_cin_q       <= cur_cin;
                alu_inp_valid_q <= cur_req;
                alu_opa_q       <= cur_req[0] ? cur_opa : '0;
                alu_opb_q       <= cur_req[1] ? cur_opb : '0;
                out_timeout_q   <= 1'b0;
            end

            if (state == S_ISSUE)     lat_cnt <= is_mul ? CNT_W'(MUL_LAT) : CNT_W'(LAT);
            else if (state == S_WAIT) lat_cnt <= lat_cnt - CNT_W'(1);

            if (state == S_WAIT && lat_done) begin
                out_res_q   <= bus.alu_res;
                out_err_q   <= bus.alu_err;
                out_oflow_q <= bus.alu_oflow;
                out_cout_q  <= bus.alu_cout;
                out_g_q     <= bus.alu_g;
                out_l_q     <= bus.alu_l;
                out_e_q     <= bus.alu_e;
            end

            if ((state == S_IDLE && accept && cur_illegal) ||
                (state == S_COLLECT && !pair_done && timer_done)) begin
                out_res_q   <= '0;
                out_err_q   <= 1'b1;
                out_oflow_q <= 1'b0;
                out_cout_q  <= 1'b0;
                out_g_q     <= 1'b0;
                out_l_q     <= 1'b0;
                out_e_q     <= 1'b0;
            end
            if (state == S_COLLECT && !pair_done && timer_done) out_timeout_q <= 1'b1;
        end
    end

    assign bus.in_ready      = in_ready_c;
    assign bus.alu_ce        = alu_ce_c;
    assign bus.alu_mode      = alu_mode_q;
    assign bus.alu_cmd       = alu_cmd_q;
    assign bus.alu_cin       = alu_cin_q;
    assign bus.alu_inp_valid = alu_inp_valid_q;
    assign bus.alu_opa       = alu_opa_q;
    assign bus.alu_opb       = alu_opb_q;
    assign bus.out_valid     = out_valid_c;
    assign bus.out_res       = out_res_q;
    assign bus.out_err       = out_err_q;
    assign bus.out_oflow     = out_oflow_q;
    assign bus.out_cout      = out_cout_q;
    assign bus.out_g         = out_g_q;
    assign bus.out_l         = out_l_q;
    assign bus.out_e         = out_e_q;
    assign bus.out_timeout   = out_timeout_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Directed-vector bench for alu_op_sequencer. Expected issues and results
// are pushed into two queues before each stimulus; a monitor on the falling
// edge pops and compares whenever alu_ce or out_valid is seen. A small ALU
// model answers with valid data only in the cycle its latency allows and
// with junk otherwise.
module tb_alu_op_sequencer;
    localparam int WIDTH     = 8;
    localparam int CMD_WIDTH = 4;
    localparam int TIMEOUT   = 16;
    localparam int LAT       = 1;
    localparam int MUL_LAT   = 2;

    typedef struct {
        int         cyc;
        logic [3:0] cmd;
        logic [1:0] mask;
        logic [7:0] opa;
        logic [7:0] opb;
    } iss_exp_t;

    typedef struct {
        int         cyc;
        logic [8:0] res;
        logic       err;
        logic       tmo;
        logic       cout;
        logic       g;
        logic       l;
        logic       e;
    } out_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   t;

    iss_exp_t issue_q[$];
    out_exp_t out_q[$];
    iss_exp_t ie;
    out_exp_t oe;

    alu_op_sequencer_if #(.WIDTH(WIDTH), .CMD_WIDTH(CMD_WIDTH)) bus ();

    alu_op_sequencer #(
        .WIDTH(WIDTH), .CMD_WIDTH(CMD_WIDTH), .TIMEOUT(TIMEOUT),
        .LAT(LAT), .MUL_LAT(MUL_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ALU model: results are only meaningful when alu_cd == 1, i.e. LAT (or
    // MUL_LAT) cycles after the issue strobe.
    logic [1:0] alu_cd = 2'd0;
    logic [8:0] model_res;
    logic [8:0] ma, mb;
    logic       res_ok;

    always @(posedge clk) begin
        if (bus.alu_ce)
            alu_cd <= (bus.alu_mode && (bus.alu_cmd == 4'd9 || bus.alu_cmd == 4'd10)) ? 2'd2 : 2'd1;
        else if (alu_cd != 2'd0)
            alu_cd <= alu_cd - 2'd1;
    end

    always_comb begin
        ma = {1'b0, bus.alu_opa};
        mb = {1'b0, bus.alu_opb};
        model_res = 9'h000;
        if (bus.alu_mode) begin
            case (bus.alu_cmd)
                4'd0:    model_res = ma + mb;
                4'd4:    model_res = ma + 9'd1;
                4'd9:    model_res = (ma + 9'd1) * (mb + 9'd1);
                default: model_res = 9'h000;
            endcase
        end else begin
            case (bus.alu_cmd)
                4'd0:    model_res = {1'b0, bus.alu_opa & bus.alu_opb};
                4'd6:    model_res = {1'b0, ~bus.alu_opa};
                4'd7:    model_res = {1'b0, ~bus.alu_opb};
                default: model_res = 9'h000;
            endcase
        end
    end

    assign res_ok        = (alu_cd == 2'd1);
    assign bus.alu_res   = res_ok ? model_res : 9'h155;
    assign bus.alu_err   = res_ok ? 1'b0 : 1'b1;
    assign bus.alu_oflow = res_ok ? 1'b0 : 1'b1;
    assign bus.alu_cout  = res_ok ? model_res[8] : 1'b1;
    assign bus.alu_g     = res_ok ? (bus.alu_opa > bus.alu_opb) : 1'b1;
    assign bus.alu_l     = res_ok ? (bus.alu_opa < bus.alu_opb) : 1'b1;
    assign bus.alu_e     = res_ok ? (bus.alu_opa == bus.alu_opb) : 1'b1;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic expect_issue(input int c, input logic [3:0] cmd, input logic [1:0] mask,
                                input logic [7:0] a, input logic [7:0] b);
        iss_exp_t x;
        x.cyc = c; x.cmd = cmd; x.mask = mask; x.opa = a; x.opb = b;
        issue_q.push_back(x);
    endtask

    task automatic expect_out(input int c, input logic [8:0] res, input logic err,
                              input logic tmo, input logic cout, input logic g,
                              input logic l, input logic e);
        out_exp_t x;
        x.cyc = c; x.res = res; x.err = err; x.tmo = tmo;
        x.cout = cout; x.g = g; x.l = l; x.e = e;
        out_q.push_back(x);
    endtask

    // Presents one beat for one cycle; must be called at a falling edge.
    task automatic apply_stimulus(input logic mode, input logic [3:0] cmd, input logic cin,
                                  input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid     = 1'b1;
        bus.in_mode      = mode;
        bus.in_cmd       = cmd;
        bus.in_cin       = cin;
        bus.in_inp_valid = iv;
        bus.in_opa       = a;
        bus.in_opb       = b;
        check_output("in_ready_at_beat", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid     = 1'b0;
        bus.in_inp_valid = 2'b00;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while ((out_q.size() != 0 || issue_q.size() != 0) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_output("drain_within_budget", 32'(out_q.size() + issue_q.size()), 32'd0);
        issue_q.delete();
        out_q.delete();
        @(negedge clk);
    endtask

    // Monitor: every issue strobe and every result pulse must match the
    // oldest outstanding expectation, including the cycle it lands in.
    always @(negedge clk) begin
        if (bus.alu_ce === 1'b1) begin
            if (issue_q.size() == 0) begin
                check_output("unexpected_issue", 32'(bus.alu_ce), 32'd0);
            end else begin
                ie = issue_q.pop_front();
                check_output("issue_cycle", 32'(cyc), 32'(ie.cyc));
                check_output("alu_cmd", 32'(bus.alu_cmd), 32'(ie.cmd));
                check_output("alu_inp_valid", 32'(bus.alu_inp_valid), 32'(ie.mask));
                check_output("alu_opa", 32'(bus.alu_opa), 32'(ie.opa));
                check_output("alu_opb", 32'(bus.alu_opb), 32'(ie.opb));
            end
        end
        if (bus.out_valid === 1'b1) begin
            if (out_q.size() == 0) begin
                check_output("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                oe = out_q.pop_front();
                check_output("out_cycle", 32'(cyc), 32'(oe.cyc));
                check_output("out_res", 32'(bus.out_res), 32'(oe.res));
                check_output("out_err", 32'(bus.out_err), 32'(oe.err));
                check_output("out_timeout", 32'(bus.out_timeout), 32'(oe.tmo));
                check_output("out_oflow", 32'(bus.out_oflow), 32'd0);
                check_output("out_cout", 32'(bus.out_cout), 32'(oe.cout));
                check_output("out_glE", 32'({bus.out_g, bus.out_l, bus.out_e}),
                             32'({oe.g, oe.l, oe.e}));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_cmd = '0; bus.in_cin = 1'b0;
        bus.in_inp_valid = 2'b00; bus.in_opa = '0; bus.in_opb = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check_output("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check_output("reset_alu_ce", 32'(bus.alu_ce), 32'd0);
        check_output("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("reset_out_res", 32'(bus.out_res), 32'd0);
        check_output("reset_out_flags", 32'({bus.out_err, bus.out_timeout, bus.out_cout}), 32'd0);
        check_output("reset_alu_inp_valid", 32'(bus.alu_inp_valid), 32'd0);

        // ADD, both operands in one beat
        t = cyc;
        expect_issue(t + 1, 4'd0, 2'b11, 8'h0F, 8'h01);
        expect_out(t + 3, 9'h010, 0, 0, 0, 1, 0, 0);
        apply_stimulus(1'b1, 4'd0, 1'b0, 2'b11, 8'h0F, 8'h01);
        wait_done();

        // AND, split beats 5 cycles apart; bus command fields on the second beat are junk
        t = cyc;
        expect_issue(t + 6, 4'd0, 2'b11, 8'hF0, 8'h3C);
        expect_out(t + 8, 9'h030, 0, 0, 0, 1, 0, 0);
        apply_stimulus(1'b0, 4'd0, 1'b0, 2'b01, 8'hF0, 8'h00);
        repeat (4) @(negedge clk);
        apply_stimulus(1'b1, 4'd4, 1'b1, 2'b10, 8'h00, 8'h3C);
        wait_done();

        // Pairing window expires with only OPA supplied
        t = cyc;
        expect_out(t + 17, 9'h000, 1, 1, 0, 0, 0, 0);
        apply_stimulus(1'b1, 4'd0, 1'b0, 2'b01, 8'h11, 8'h22);
        wait_done();

        // Second beat at T+TIMEOUT is still accepted; the issue clears out_timeout
        t = cyc;
        expect_issue(t + 17, 4'd0, 2'b11, 8'h20, 8'h05);
        expect_out(t + 19, 9'h025, 0, 0, 0, 1, 0, 0);
        apply_stimulus(1'b1, 4'd0, 1'b0, 2'b01, 8'h20, 8'h00);
        repeat (15) @(negedge clk);
        apply_stimulus(1'b1, 4'd0, 1'b0, 2'b10, 8'h00, 8'h05);
        wait_done();

        // INC_A: OPB supplied but must be masked off
        t = cyc;
        expect_issue(t + 1, 4'd4, 2'b01, 8'h41, 8'h00);
        expect_out(t + 3, 9'h042, 0, 0, 0, 1, 0, 0);
        apply_stimulus(1'b1, 4'd4, 1'b0, 2'b11, 8'h41, 8'hAA);
        wait_done();

        // Logical NOT_A (mask 01) and NOT_B (mask 10)
        t = cyc;
        expect_issue(t + 1, 4'd6, 2'b01, 8'h0F, 8'h00);
        expect_out(t + 3, 9'h0F0, 0, 0, 0, 1, 0, 0);
        apply_stimulus(1'b0, 4'd6, 1'b0, 2'b01, 8'h0F, 8'h77);
        wait_done();

        t = cyc;
        expect_issue(t + 1, 4'd7, 2'b10, 8'h00, 8'h55);
        expect_out(t + 3, 9'h0AA, 0, 0, 0, 0, 1, 0);
        apply_stimulus(1'b0, 4'd7, 1'b0, 2'b10, 8'h33, 8'h55);
        wait_done();

        // Multiply takes MUL_LAT cycles
        t = cyc;
        expect_issue(t + 1, 4'd9, 2'b11, 8'h03, 8'h04);
        expect_out(t + 4, 9'h014, 0, 0, 0, 0, 1, 0);
        apply_stimulus(1'b1, 4'd9, 1'b0, 2'b11, 8'h03, 8'h04);
        wait_done();

        // Illegal commands in both modes: immediate error, never issued
        t = cyc;
        expect_out(t + 1, 9'h000, 1, 0, 0, 0, 0, 0);
        apply_stimulus(1'b1, 4'd12, 1'b0, 2'b11, 8'h12, 8'h34);
        wait_done();

        t = cyc;
        expect_out(t + 1, 9'h000, 1, 0, 0, 0, 0, 0);
        apply_stimulus(1'b0, 4'd14, 1'b0, 2'b11, 8'h56, 8'h78);
        wait_done();

        // Reset pulsed during WAIT of a multiply: back to IDLE, outputs cleared, no result pulse
        t = cyc;
        expect_issue(t + 1, 4'd9, 2'b11, 8'h06, 8'h07);
        apply_stimulus(1'b1, 4'd9, 1'b0, 2'b11, 8'h06, 8'h07);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("rst_wait_in_ready", 32'(bus.in_ready), 32'd1);
        check_output("rst_wait_alu_ce", 32'(bus.alu_ce), 32'd0);
        check_output("rst_wait_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("rst_wait_out_res", 32'(bus.out_res), 32'd0);
        check_output("rst_wait_alu_drive", 32'({bus.alu_inp_valid, bus.alu_opa, bus.alu_opb, bus.alu_cmd}), 32'd0);
        repeat (5) @(negedge clk);
        wait_done();

        // Normal operation resumes: ADD with carry out
        t = cyc;
        expect_issue(t + 1, 4'd0, 2'b11, 8'h7F, 8'h81);
        expect_out(t + 3, 9'h100, 0, 0, 1, 0, 1, 0);
        apply_stimulus(1'b1, 4'd0, 1'b0, 2'b11, 8'h7F, 8'h81);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
